hazard_mc: RTL and testbench
============================

# hazard_mc

Parametrised pipeline hazard controller for the 5-stage MIPS core, successor to the single-cycle hazard unit. It provides GPR forwarding to D and E, independent HI/LO forwarding, and load-use and branch-operand stalls. It also stalls the pipeline for a multi-cycle divide using an internal sequencer, and flushes the pipeline on an M-stage exception. It sits beside the datapath, takes stage register fields, and drives every stall and flush enable.

## Interface
- `REG_AW`, 5: register address width.
- `DIV_CYCLES`, 32: divider busy cycles, legal 2..63.
- `BRANCH_IN_D`, 1: 1 = branches resolve in D (D forwarding and branch stall active); 0 = forwardaD/forwardbD and branch stall tied 0.

Ports:
- `clk` in 1: clock. One clock domain; reset is synchronous and active-high.
- `rst` in 1: reset.
- `rsD`, `rtD` in REG_AW: D-stage source registers.
- `branchD`, `jumpregD` in 1: branch compare in D; jr/jalr (uses rs only).
- `rsE`, `rtE`, `writeregE` in REG_AW: E-stage sources and destination.
- `regwriteE`, `memtoregE`, `hilo_readE`, `divE` in 1: E-stage controls. `hilo_readE` marks mfhi/mflo; `divE` marks div/divu.
- `writeregM` in REG_AW; `regwriteM`, `memtoregM`, `excM` in 1: M-stage controls. `excM` = exception taken in M.
- `hilo_weM`, `hilo_weW` in 2: HI/LO write enables, bit1 = HI, bit0 = LO.
- `writeregW` in REG_AW; `regwriteW` in 1.
- `forwardaD`, `forwardbD` out 1: forward M result to D compare.
- `forwardaE`, `forwardbE`, `forwardhiE`, `forwardloE` out 2: 00 = none, 10 = from M, 01 = from W for GPR; HI/LO use 00 = none, 01 = from M, 10 = from W.
- `stallF`, `stallD`, `stallE` out 1: hold the stage register.
- `flushD`, `flushE`, `flushM`, `flushW` out 1: insert a bubble into the stage register.
- `div_startE` out 1: one-cycle start pulse to the divider.
- `div_doneE` out 1: divider result valid this cycle.

## Operation
- GPR forwarding to E: source ≠ 0, M match with regwriteM → 10; else W match with regwriteW → 01; else 00. M has priority.
- Forwarding to D: `BRANCH_IN_D`=1 only. 1 when source ≠ 0, matches writeregM, and regwriteM.
- HI/LO forwarding is per half and applies only when hilo_readE. The HI half uses bit1 of the write enables and the LO half uses bit0. M (01) has priority over W (10); otherwise 00.
- lwstall = memtoregE & regwriteE & writeregE≠0 & (writeregE==rsD | writeregE==rtD).
- brstall (BRANCH_IN_D=1):
  - applies when (branchD|jumpregD) and the source is ≠ 0;
  - triggers on a regwriteE match with writeregE, or a memtoregM match with writeregM;
  - rtD is ignored when jumpregD.
- Divide sequencer states: IDLE, BUSY, DONE; counter width 6.
  - IDLE & divE & !excM → div_startE=1, cnt←DIV_CYCLES−1, go BUSY.
  - BUSY: cnt decrements each cycle; cnt==1 → DONE.
  - DONE: div_doneE=1; → IDLE unconditionally.
  - divstall = (IDLE & divE) | BUSY.
- Outputs when excM=0:
  - stallF = stallD = lwstall|brstall|divstall.
  - stallE = divstall.
  - flushE = (lwstall|brstall) & !divstall.
  - flushM = divstall.
  - flushD = flushW = 0.
- excM=1 overrides everything:
  - all stalls 0; flushD/E/M/W = 1; div_startE = 0;
  - sequencer → IDLE, cnt ← 0, including mid-BUSY (divide aborted).
- rst=1:
  - state IDLE, cnt 0;
  - stalls 0, flushes 1, div_startE/div_doneE 0, all forward selects 00.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and current state, with zero latency.
- The sequencer updates on the rising clk edge.
- A divide occupies E for DIV_CYCLES+1 cycles: the start cycle, DIV_CYCLES−1 BUSY cycles, and 1 DONE cycle. It advances to M at the edge ending DONE.
- Back-to-back divides: the next divE in E sees IDLE the cycle after DONE and starts immediately. There is no dead cycle beyond DONE.
- A load-use or branch hazard that coincides with divstall is absorbed: E holds, so flushE=0.
- A divide in E when excM rises: no start pulse; it restarts only if the instruction is re-fetched.

## Structure
- Shared package `hazard_pkg` holds:
  - constants FWD_NONE/FWD_W/FWD_M (00/01/10) and HILO_NONE/HILO_M/HILO_W (00/01/10);
  - the div state typedef (IDLE=0, BUSY=1, DONE=2).
- One sub-module, `div_seq_ctrl`, holds the FSM and counter. It takes clk, rst, divE and excM, and drives divstall, div_startE and div_doneE.
- All forwarding and stall logic stays in the top level.

## Test plan
- Forwarding priority: rsE=rtE=5, writeregM=writeregW=5, regwriteM=regwriteW=1 → forwardaE=forwardbE=10. Same with regwriteM=0 → 01. rsE=0 → 00.
- Load-use: memtoregE=regwriteE=1, writeregE=8, rtD=8 → stallF=stallD=flushE=1, stallE=0, for exactly one cycle.
- Divide, DIV_CYCLES=4: divE held → div_startE in cycle 0 only; stallE=1 in cycles 0–3; cycle 4 div_doneE=1 with all stalls 0; flushM=1 in cycles 0–3.
- Abort: excM=1 in the 2nd BUSY cycle → flushD/E/M/W=1, stalls 0; next cycle state is IDLE with no div_doneE pulse.
- HI/LO: hilo_readE=1, hilo_weM=2'b10, hilo_weW=2'b01 → forwardhiE=01, forwardloE=10.
- Branch: branchD=1, rsD=3, regwriteE=1, writeregE=3 → stallD=1. jumpregD=1, rtD=3, rsD=4 → no stall. With BRANCH_IN_D=0, both cases give no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard controller and its divide sequencer.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_W     = 2'b01;
    localparam logic [1:0] FWD_M     = 2'b10;

    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_M    = 2'b01;
    localparam logic [1:0] HILO_W    = 2'b10;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/hazard_mc_div_seq.sv
// Multi-cycle divide sequencer: holds E while the divider runs, aborts on exception.
module div_seq_ctrl
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic divE,
    input  logic excM,
    output logic divstall,
    output logic div_startE,
    output logic div_doneE
);

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and sequencer outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        divstall   = 1'b0;
        div_startE = 1'b0;
        div_doneE  = 1'b0;
        case (state_q)
            IDLE: begin
                divstall = divE;
                if (divE && !excM) begin
                    div_startE = 1'b1;
                    state_d    = BUSY;
                    cnt_d      = CNT_START;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                divstall = 1'b1;
                cnt_d    = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                div_doneE = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        // An exception kills any divide in flight, including mid-BUSY
        if (excM) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            state_d = state_d;
        end
        if (rst) begin
            divstall   = 1'b0;
            div_startE = 1'b0;
            div_doneE  = 1'b0;
        end else begin
            divstall = divstall;
        end
    end

endmodule

// File: rtl/hazard_mc.sv
// Pipeline hazard controller: GPR and HI/LO forwarding, load-use/branch/divide stalls,
// and exception flush for the 5-stage core.
module hazard_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int DIV_CYCLES  = 32,
    parameter int BRANCH_IN_D = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jumpregD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              hilo_readE,
    input  logic              divE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              excM,
    input  logic [1:0]        hilo_weM,
    input  logic [1:0]        hilo_weW,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic [1:0]        forwardhiE,
    output logic [1:0]        forwardloE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              div_startE,
    output logic              div_doneE
);

    localparam logic [REG_AW-1:0] ZERO_REG = {REG_AW{1'b0}};
    localparam logic              BR_EN    = (BRANCH_IN_D != 0);

    logic divstall_s;
    logic lwstall_s;
    logic brstall_s;
    logic br_hz_rs_s;
    logic br_hz_rt_s;

    div_seq_ctrl #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk        (clk),
        .rst        (rst),
        .divE       (divE),
        .excM       (excM),
        .divstall   (divstall_s),
        .div_startE (div_startE),
        .div_doneE  (div_doneE)
    );

    // Hazard detection terms
    always_comb begin
        lwstall_s  = memtoregE && regwriteE && (writeregE != ZERO_REG) &&
                     ((writeregE == rsD) || (writeregE == rtD));
        br_hz_rs_s = (rsD != ZERO_REG) &&
                     ((regwriteE && (writeregE == rsD)) || (memtoregM && (writeregM == rsD)));
        // jr/jalr only read rs, so rt can never cause their stall
        br_hz_rt_s = !jumpregD && (rtD != ZERO_REG) &&
                     ((regwriteE && (writeregE == rtD)) || (memtoregM && (writeregM == rtD)));
        brstall_s  = BR_EN && (branchD || jumpregD) && (br_hz_rs_s || br_hz_rt_s);
    end

    // Forwarding selects
    always_comb begin
        forwardaD  = 1'b0;
        forwardbD  = 1'b0;
        forwardaE  = FWD_NONE;
        forwardbE  = FWD_NONE;
        forwardhiE = HILO_NONE;
        forwardloE = HILO_NONE;
        if (!rst) begin
            forwardaD = BR_EN && (rsD != ZERO_REG) && (rsD == writeregM) && regwriteM;
            forwardbD = BR_EN && (rtD != ZERO_REG) && (rtD == writeregM) && regwriteM;

            if ((rsE != ZERO_REG) && (rsE == writeregM) && regwriteM)      forwardaE = FWD_M;
            else if ((rsE != ZERO_REG) && (rsE == writeregW) && regwriteW) forwardaE = FWD_W;
            else                                                           forwardaE = FWD_NONE;

            if ((rtE != ZERO_REG) && (rtE == writeregM) && regwriteM)      forwardbE = FWD_M;
            else if ((rtE != ZERO_REG) && (rtE == writeregW) && regwriteW) forwardbE = FWD_W;
            else                                                           forwardbE = FWD_NONE;

            if (hilo_readE && hilo_weM[1])      forwardhiE = HILO_M;
            else if (hilo_readE && hilo_weW[1]) forwardhiE = HILO_W;
            else                                forwardhiE = HILO_NONE;

            if (hilo_readE && hilo_weM[0])      forwardloE = HILO_M;
            else if (hilo_readE && hilo_weW[0]) forwardloE = HILO_W;
            else                                forwardloE = HILO_NONE;
        end else begin
            forwardaD = 1'b0;
        end
    end

    // Stall and flush enables; reset and exception both drain the pipe
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b1;
        flushE = 1'b1;
        flushM = 1'b1;
        flushW = 1'b1;
        if (!rst && !excM) begin
            stallF = lwstall_s || brstall_s || divstall_s;
            stallD = lwstall_s || brstall_s || divstall_s;
            stallE = divstall_s;
            flushD = 1'b0;
            flushE = (lwstall_s || brstall_s) && !divstall_s;
            flushM = divstall_s;
            flushW = 1'b0;
        end else begin
            stallF = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_mc.sv
// Randomised self-checking bench for hazard_mc with a behavioural reference model.
module tb_hazard_mc;

    localparam int AW = 5;
    localparam int DC = 4;

    typedef struct packed {
        logic       fad, fbd;
        logic [1:0] fae, fbe, fhi, flo;
        logic       sf, sd, se, fd, fe, fm, fw, start, done;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          branchD, jumpregD, regwriteE, memtoregE, hilo_readE, divE;
    logic          regwriteM, memtoregM, excM, regwriteW;
    logic [1:0]    hilo_weM, hilo_weW;

    exp_t act1, act0;
    int   checks = 0;
    int   errors = 0;
    int   age = -1;   // -1: no divide; k>=1: k-th cycle after the start cycle

    always #5 clk = ~clk;

    hazard_mc #(.REG_AW(AW), .DIV_CYCLES(DC), .BRANCH_IN_D(1)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpregD(jumpregD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .hilo_readE(hilo_readE), .divE(divE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM), .excM(excM),
        .hilo_weM(hilo_weM), .hilo_weW(hilo_weW), .writeregW(writeregW), .regwriteW(regwriteW),
        .forwardaD(act1.fad), .forwardbD(act1.fbd), .forwardaE(act1.fae), .forwardbE(act1.fbe),
        .forwardhiE(act1.fhi), .forwardloE(act1.flo), .stallF(act1.sf), .stallD(act1.sd),
        .stallE(act1.se), .flushD(act1.fd), .flushE(act1.fe), .flushM(act1.fm),
        .flushW(act1.fw), .div_startE(act1.start), .div_doneE(act1.done));

    hazard_mc #(.REG_AW(AW), .DIV_CYCLES(DC), .BRANCH_IN_D(0)) dut0 (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpregD(jumpregD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .hilo_readE(hilo_readE), .divE(divE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM), .excM(excM),
        .hilo_weM(hilo_weM), .hilo_weW(hilo_weW), .writeregW(writeregW), .regwriteW(regwriteW),
        .forwardaD(act0.fad), .forwardbD(act0.fbd), .forwardaE(act0.fae), .forwardbE(act0.fbe),
        .forwardhiE(act0.fhi), .forwardloE(act0.flo), .stallF(act0.sf), .stallD(act0.sd),
        .stallE(act0.se), .flushD(act0.fd), .flushE(act0.fe), .flushM(act0.fm),
        .flushW(act0.fw), .div_startE(act0.start), .div_doneE(act0.done));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] gpr_sel(input logic [AW-1:0] src);
        if (src == 0) return 2'b00;
        if (regwriteM && writeregM == src) return 2'b10;
        if (regwriteW && writeregW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] hl_sel(input logic wm, input logic ww);
        if (!hilo_readE) return 2'b00;
        if (wm) return 2'b01;
        if (ww) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit produced_ahead(input logic [AW-1:0] r);
        return (r != 0) && ((regwriteE && writeregE == r) || (memtoregM && writeregM == r));
    endfunction

    function automatic exp_t model(input bit bid);
        exp_t e;
        bit lw, br, dv;
        e = '0;
        if (rst) begin
            {e.fd, e.fe, e.fm, e.fw} = 4'b1111;
            return e;
        end
        e.fae = gpr_sel(rsE);
        e.fbe = gpr_sel(rtE);
        e.fhi = hl_sel(hilo_weM[1], hilo_weW[1]);
        e.flo = hl_sel(hilo_weM[0], hilo_weW[0]);
        if (bid) begin
            e.fad = (rsD != 0) && regwriteM && (writeregM == rsD);
            e.fbd = (rtD != 0) && regwriteM && (writeregM == rtD);
        end
        e.done = (age == DC);
        if (excM) begin
            {e.fd, e.fe, e.fm, e.fw} = 4'b1111;
            return e;
        end
        lw = memtoregE && regwriteE && (writeregE != 0) && (writeregE == rsD || writeregE == rtD);
        br = bid && (branchD || jumpregD) &&
             (produced_ahead(rsD) || (!jumpregD && produced_ahead(rtD)));
        dv = (age < 0 && divE) || (age >= 1 && age < DC);
        e.sf    = lw || br || dv;
        e.sd    = e.sf;
        e.se    = dv;
        e.fe    = (lw || br) && !dv;
        e.fm    = dv;
        e.start = (age < 0) && divE;
        return e;
    endfunction

    // Divide progress in the model: a counter of cycles since the start pulse
    always @(posedge clk) begin
        if (rst || excM)          age <= -1;
        else if (age < 0)         age <= divE ? 1 : -1;
        else if (age == DC)       age <= -1;
        else                      age <= age + 1;
    end

    always @(negedge clk) begin
        chk("model_vs_dut_bid1", 32'(act1), 32'(model(1'b1)));
        chk("model_vs_dut_bid0", 32'(act0), 32'(model(1'b0)));
    end

    task automatic clear_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {branchD, jumpregD, regwriteE, memtoregE, hilo_readE, divE} = '0;
        {regwriteM, memtoregM, excM, regwriteW} = '0;
        hilo_weM = 2'b00;
        hilo_weW = 2'b00;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        divE = 1'b1;
        rsE = 5'd5; writeregM = 5'd5; regwriteM = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_stalls", 32'({act1.sf, act1.sd, act1.se}), 32'd0);
        chk("rst_flushes", 32'({act1.fd, act1.fe, act1.fm, act1.fw}), 32'hF);
        chk("rst_start", 32'(act1.start), 32'd0);
        chk("rst_fwdaE", 32'(act1.fae), 32'd0);

        next_cycle();
        rst = 1'b0;
        clear_inputs();
        rsE = 5'd5; rtE = 5'd5; writeregM = 5'd5; writeregW = 5'd5;
        regwriteM = 1'b1; regwriteW = 1'b1;
        @(negedge clk);
        chk("fwd_M_prio", 32'({act1.fae, act1.fbe}), 32'b1010);
        next_cycle();
        regwriteM = 1'b0;
        @(negedge clk);
        chk("fwd_W", 32'({act1.fae, act1.fbe}), 32'b0101);
        next_cycle();
        rsE = 5'd0;
        @(negedge clk);
        chk("fwd_r0", 32'(act1.fae), 32'd0);

        next_cycle();
        clear_inputs();
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd8; rtD = 5'd8;
        @(negedge clk);
        chk("lw_stall", 32'({act1.sf, act1.sd, act1.fe, act1.se}), 32'b1110);
        next_cycle();
        memtoregE = 1'b0; regwriteE = 1'b0;
        @(negedge clk);
        chk("lw_released", 32'({act1.sf, act1.sd, act1.fe}), 32'd0);

        next_cycle();
        clear_inputs();
        divE = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("div_start", 32'(act1.start), 32'(c == 0));
            chk("div_stallE", 32'(act1.se), 32'(c < 4));
            chk("div_flushM", 32'(act1.fm), 32'(c < 4));
            chk("div_done", 32'(act1.done), 32'(c == 4));
            next_cycle();
        end
        divE = 1'b0;

        next_cycle();
        divE = 1'b1;
        @(negedge clk);
        chk("abort_start", 32'(act1.start), 32'd1);
        next_cycle();
        next_cycle();
        excM = 1'b1;
        @(negedge clk);
        chk("abort_flushes", 32'({act1.fd, act1.fe, act1.fm, act1.fw}), 32'hF);
        chk("abort_stalls", 32'({act1.sf, act1.sd, act1.se, act1.start}), 32'd0);
        next_cycle();
        excM = 1'b0; divE = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_idle", 32'({act1.se, act1.done}), 32'd0);
            next_cycle();
        end

        clear_inputs();
        hilo_readE = 1'b1; hilo_weM = 2'b10; hilo_weW = 2'b01;
        @(negedge clk);
        chk("hilo_fwd", 32'({act1.fhi, act1.flo}), 32'b0110);

        next_cycle();
        clear_inputs();
        branchD = 1'b1; rsD = 5'd3; regwriteE = 1'b1; writeregE = 5'd3;
        @(negedge clk);
        chk("br_stall", 32'(act1.sd), 32'd1);
        chk("br_stall_off", 32'(act0.sd), 32'd0);
        next_cycle();
        branchD = 1'b0; jumpregD = 1'b1; rtD = 5'd3; rsD = 5'd4;
        @(negedge clk);
        chk("jr_rt_ignored", 32'(act1.sd), 32'd0);
        chk("jr_off", 32'(act0.sd), 32'd0);

        for (int n = 0; n < 4000; n++) begin
            next_cycle();
            rst        = ($urandom_range(0, 99) == 0);
            excM       = ($urandom_range(0, 24) == 0);
            divE       = ($urandom_range(0, 2) == 0);
            rsD        = AW'($urandom_range(0, 7));
            rtD        = AW'($urandom_range(0, 7));
            rsE        = AW'($urandom_range(0, 7));
            rtE        = AW'($urandom_range(0, 7));
            writeregE  = AW'($urandom_range(0, 7));
            writeregM  = AW'($urandom_range(0, 7));
            writeregW  = AW'($urandom_range(0, 7));
            branchD    = ($urandom_range(0, 3) == 0);
            jumpregD   = ($urandom_range(0, 3) == 0);
            regwriteE  = 1'($urandom);
            memtoregE  = ($urandom_range(0, 2) == 0);
            hilo_readE = 1'($urandom);
            regwriteM  = 1'($urandom);
            memtoregM  = ($urandom_range(0, 2) == 0);
            regwriteW  = 1'($urandom);
            hilo_weM   = 2'($urandom);
            hilo_weW   = 2'($urandom);
        end
        next_cycle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
